rv32_mem_arbiter: RTL and testbench
===================================

RV32_MEM_ARBITER -- requirements
Module: rv32_mem_arbiter

Interface
REQ-001 SHALL have parameter FAIR_LIMIT, default 4, meaning the maximum number of consecutive data grants while an instruction request waits (range 1..15).
REQ-002 SHALL have one clock, `clk`, input, 1 bit; all state updates on its rising edge.
REQ-003 SHALL have reset `reset`, input, 1 bit, asynchronous and active-low.
REQ-004 SHALL have instruction master port:
- instr_address_in, in, 32
- instr_read_in, in, 1
- instr_read_value_out, out, 32
- instr_ready_out, out, 1
REQ-005 SHALL have data master port:
- data_address_in, in, 32
- data_read_in, in, 1
- data_write_in, in, 1
- data_write_mask_in, in, 4
- data_write_value_in, in, 32
- data_read_value_out, out, 32
- data_ready_out, out, 1
REQ-006 SHALL have shared memory port:
- mem_address_out, out, 32
- mem_read_out, out, 1
- mem_write_out, out, 1
- mem_write_mask_out, out, 4
- mem_write_value_out, out, 32
- mem_read_value_in, in, 32
- mem_ready_in, in, 1

Function
REQ-007 SHALL implement FSM states IDLE, BUSY_INSTR, BUSY_DATA.
REQ-008 Requests: instruction = instr_read_in; data = data_read_in | data_write_in. A master holds its request and payload stable until it sees its ready.
REQ-009 Selection in IDLE:
- data request and fair_count < FAIR_LIMIT -> data;
- else instruction request -> instruction;
- else data request -> data;
- else nothing.
REQ-010 In IDLE, the selected master SHALL be forwarded to the mem port combinationally in the same cycle, giving zero added latency.
REQ-011 When a selected transfer sees mem_ready_in=0 in IDLE, the FSM SHALL move to BUSY_INSTR or BUSY_DATA.
REQ-012 In a BUSY state, the grant SHALL stay locked to that master regardless of the other request, until mem_ready_in=1, then return to IDLE.
REQ-013 A transfer completing in the cycle it is issued SHALL leave the FSM in IDLE, so back-to-back single-cycle transfers are possible.
REQ-014 instr_ready_out = mem_ready_in & (instruction granted this cycle); data_ready_out = mem_ready_in & (data granted this cycle); the non-granted ready SHALL be 0.
REQ-015 mem_read_value_in SHALL drive both instr_read_value_out and data_read_value_out unregistered.
REQ-016 Instruction grants drive mem_read_out=1, mem_write_out=0, mem_write_mask_out=0, mem_write_value_out=0.
REQ-017 Data grants pass data_read_in, data_write_in, mask and value through unchanged.
REQ-018 With no grant, mem_read_out=mem_write_out=0, mem_write_mask_out=0, mem_address_out=0.
REQ-019 fair_count (4 bits) on each completed transfer:
- completed data transfer while instr_read_in=1 -> increment, saturating at 15;
- completed instruction transfer -> clear;
- completion with instr_read_in=0 -> clear.
REQ-020 A data request with both read and write asserted SHALL be forwarded unchanged; the arbiter does not check it.
REQ-021 A master dropping its request mid-BUSY is illegal; the arbiter SHALL still hold the grant until mem_ready_in=1.

Reset
REQ-022 On reset low, the state SHALL go to IDLE and fair_count to 0 immediately (asynchronously).
REQ-023 While reset is low, mem_read_out, mem_write_out, instr_ready_out and data_ready_out SHALL be 0, and mem_write_mask_out, mem_address_out and mem_write_value_out SHALL be 0.
REQ-024 A transfer interrupted by reset SHALL be abandoned; after reset is released, arbitration restarts from IDLE.

Structure
REQ-025 The state enum and the fair_count width constant SHALL live in shared package rv32_arbiter_pkg.
REQ-026 No sub-module; the FSM, counter and output mux are a single module placed between rv32 and the memory.

Verification
REQ-027 Single instruction fetch: instr_read_in=1, address 0x100, mem_ready_in=1 same cycle -> mem_read_out=1, mem_address_out=0x100, instr_ready_out=1 in that cycle; FSM stays IDLE.
REQ-028 Simultaneous requests: instr 0x200 and data write 0x80000000 (mask 0xF, value 0xDEADBEEF), fair_count=0 -> data granted first with mem_write_out=1; instruction granted the next cycle.
REQ-029 Wait states: data read, mem_ready_in low for 3 cycles, instruction request arriving in cycle 2 -> grant stays data; data_ready_out=1 only in cycle 4; instr_ready_out=0 throughout.
REQ-030 Fairness: FAIR_LIMIT=2, data and instr requesting continuously, mem_ready_in=1 -> grant sequence D,D,I,D,D,I.
REQ-031 Reset mid-transfer: BUSY_DATA with mem_ready_in=0, reset driven low -> mem_write_out and mem_read_out drop without waiting for a clock edge; after release, an instruction-only request is granted from IDLE.
REQ-032 Idle bus: no requests -> all mem_* outputs 0 and both readies 0 while mem_ready_in toggles.

Source files
------------

// File: rtl/rv32_arbiter_pkg.sv
// Shared types for the rv32 instruction/data memory arbiter.
package rv32_arbiter_pkg;

  localparam int FAIR_W = 4;
  localparam logic [FAIR_W-1:0] FAIR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_INSTR,
    BUSY_DATA
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_INSTR,
    GNT_DATA
  } grant_t;

endpackage

// File: rtl/rv32_mem_arbiter.sv
// Two-master (instruction/data) arbiter in front of a single memory port.
// Grants in IDLE are forwarded the same cycle; wait states lock the grant.
//
// state      | meaning
// IDLE       | no transfer outstanding, arbitrate combinationally
// BUSY_INSTR | instruction transfer waiting for mem_ready_in
// BUSY_DATA  | data transfer waiting for mem_ready_in
module rv32_mem_arbiter
  import rv32_arbiter_pkg::*;
#(
  parameter int unsigned FAIR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out,
  output logic [31:0] mem_address_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [3:0]  mem_write_mask_out,
  output logic [31:0] mem_write_value_out,
  input  logic [31:0] mem_read_value_in,
  input  logic        mem_ready_in
);

  localparam logic [FAIR_W-1:0] LIMIT = FAIR_W'(FAIR_LIMIT);

  arb_state_t        state;
  logic [FAIR_W-1:0] fair_count;
  grant_t            grant;
  logic              instr_req;
  logic              data_req;

  assign instr_req = instr_read_in;
  assign data_req  = data_read_in | data_write_in;

  // Reset gates the grant directly so the bus goes quiet without a clock edge.
  always_comb begin
    grant = GNT_NONE;
    case (state)
      IDLE: begin
        if (data_req && (fair_count < LIMIT)) grant = GNT_DATA;
        else if (instr_req)                   grant = GNT_INSTR;
        else if (data_req)                    grant = GNT_DATA;
      end
      BUSY_INSTR: grant = GNT_INSTR;
      BUSY_DATA:  grant = GNT_DATA;
      default:    grant = GNT_NONE;
    endcase
    if (!reset) grant = GNT_NONE;
  end

  assign instr_read_value_out = mem_read_value_in;
  assign data_read_value_out  = mem_read_value_in;

  always_comb begin
    mem_address_out     = '0;
    mem_read_out        = 1'b0;
    mem_write_out       = 1'b0;
    mem_write_mask_out  = '0;
    mem_write_value_out = '0;
    instr_ready_out     = 1'b0;
    data_ready_out      = 1'b0;
    case (grant)
      GNT_INSTR: begin
        mem_address_out = instr_address_in;
        mem_read_out    = 1'b1;
        instr_ready_out = mem_ready_in;
      end
      GNT_DATA: begin
        mem_address_out     = data_address_in;
        mem_read_out        = data_read_in;
        mem_write_out       = data_write_in;
        mem_write_mask_out  = data_write_mask_in;
        mem_write_value_out = data_write_value_in;
        data_ready_out      = mem_ready_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      fair_count <= '0;
    end else if (grant != GNT_NONE) begin
      if (mem_ready_in) begin
        state <= IDLE;
        // Only data completions while an instruction fetch waits count against fairness.
        if (grant == GNT_DATA && instr_read_in)
          fair_count <= (fair_count == FAIR_MAX) ? fair_count : fair_count + 1'b1;
        else
          fair_count <= '0;
      end else begin
        state <= (grant == GNT_INSTR) ? BUSY_INSTR : BUSY_DATA;
      end
    end
  end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Scoreboard bench for rv32_mem_arbiter: stimulus pushes expected completions,
// a negedge monitor pops one per ready pulse and compares the memory-side view.
module tb_rv32_mem_arbiter;

  typedef struct {
    logic        is_data;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] val;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_address_in;
  logic        instr_read_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic [31:0] data_address_in;
  logic        data_read_in;
  logic        data_write_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_ready_out;
  logic [31:0] mem_address_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic [3:0]  mem_write_mask_out;
  logic [31:0] mem_write_value_out;
  logic [31:0] mem_read_value_in;
  logic        mem_ready_in;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  rv32_mem_arbiter #(.FAIR_LIMIT(2)) dut (
    .clk                  (clk),
    .reset                (reset),
    .instr_address_in     (instr_address_in),
    .instr_read_in        (instr_read_in),
    .instr_read_value_out (instr_read_value_out),
    .instr_ready_out      (instr_ready_out),
    .data_address_in      (data_address_in),
    .data_read_in         (data_read_in),
    .data_write_in        (data_write_in),
    .data_write_mask_in   (data_write_mask_in),
    .data_write_value_in  (data_write_value_in),
    .data_read_value_out  (data_read_value_out),
    .data_ready_out       (data_ready_out),
    .mem_address_out      (mem_address_out),
    .mem_read_out         (mem_read_out),
    .mem_write_out        (mem_write_out),
    .mem_write_mask_out   (mem_write_mask_out),
    .mem_write_value_out  (mem_write_value_out),
    .mem_read_value_in    (mem_read_value_in),
    .mem_ready_in         (mem_ready_in)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic is_data, input logic [31:0] addr, input logic rd,
                      input logic wr, input logic [3:0] mask, input logic [31:0] val,
                      input logic [31:0] rdata);
    exp_t e;
    e.is_data = is_data;
    e.addr    = addr;
    e.rd      = rd;
    e.wr      = wr;
    e.mask    = mask;
    e.val     = val;
    e.rdata   = rdata;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_address_in    = '0;
    instr_read_in       = 1'b0;
    data_address_in     = '0;
    data_read_in        = 1'b0;
    data_write_in       = 1'b0;
    data_write_mask_in  = '0;
    data_write_value_in = '0;
    mem_read_value_in   = '0;
    mem_ready_in        = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_instr_ready"}, 32'(instr_ready_out), 32'd0);
    chk({tag, "_data_ready"}, 32'(data_ready_out), 32'd0);
    chk({tag, "_mem_read"}, 32'(mem_read_out), 32'd0);
    chk({tag, "_mem_write"}, 32'(mem_write_out), 32'd0);
    chk({tag, "_mem_mask"}, 32'(mem_write_mask_out), 32'd0);
    chk({tag, "_mem_addr"}, mem_address_out, 32'd0);
    chk({tag, "_mem_value"}, mem_write_value_out, 32'd0);
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (instr_ready_out === 1'b1 || data_ready_out === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", {30'd0, instr_ready_out, data_ready_out}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("instr_ready", 32'(instr_ready_out), 32'(!e.is_data));
          chk("data_ready", 32'(data_ready_out), 32'(e.is_data));
          chk("mem_addr", mem_address_out, e.addr);
          chk("mem_read", 32'(mem_read_out), 32'(e.rd));
          chk("mem_write", 32'(mem_write_out), 32'(e.wr));
          chk("mem_mask", 32'(mem_write_mask_out), 32'(e.mask));
          chk("mem_value", mem_write_value_out, e.val);
          chk("instr_rdata", instr_read_value_out, e.rdata);
          chk("data_rdata", data_read_value_out, e.rdata);
        end
      end
    end
  end

  initial begin
    clear_inputs();
    reset = 1'b0;
    // Requests present while in reset must not reach the bus.
    instr_read_in    = 1'b1;
    instr_address_in = 32'h0000_0111;
    data_write_in    = 1'b1;
    data_address_in  = 32'h0000_0123;
    data_write_mask_in  = 4'hF;
    data_write_value_in = 32'h1234_5678;
    mem_ready_in     = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    step();
    clear_inputs();
    reset = 1'b1;

    // Single-cycle instruction fetch
    step();
    instr_read_in     = 1'b1;
    instr_address_in  = 32'h0000_0100;
    mem_ready_in      = 1'b1;
    mem_read_value_in = 32'h1234_5678;
    push(1'b0, 32'h0000_0100, 1'b1, 1'b0, 4'h0, 32'h0, 32'h1234_5678);
    step();
    clear_inputs();

    // Simultaneous requests: data first, instruction next cycle
    step();
    instr_read_in       = 1'b1;
    instr_address_in    = 32'h0000_0200;
    data_write_in       = 1'b1;
    data_address_in     = 32'h8000_0000;
    data_write_mask_in  = 4'hF;
    data_write_value_in = 32'hDEAD_BEEF;
    mem_ready_in        = 1'b1;
    push(1'b1, 32'h8000_0000, 1'b0, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h0);
    step();
    data_write_in       = 1'b0;
    data_address_in     = '0;
    data_write_mask_in  = '0;
    data_write_value_in = '0;
    mem_read_value_in   = 32'hCAFE_0001;
    push(1'b0, 32'h0000_0200, 1'b1, 1'b0, 4'h0, 32'h0, 32'hCAFE_0001);
    step();
    clear_inputs();

    // Wait states with an instruction request arriving mid-transfer
    step();
    data_read_in    = 1'b1;
    data_address_in = 32'h0000_0040;
    mem_ready_in    = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) begin
        instr_read_in    = 1'b1;
        instr_address_in = 32'h0000_0500;
      end
      @(negedge clk);
      chk("wait_instr_ready", 32'(instr_ready_out), 32'd0);
      chk("wait_data_ready", 32'(data_ready_out), 32'd0);
      chk("wait_locked_addr", mem_address_out, 32'h0000_0040);
      chk("wait_mem_read", 32'(mem_read_out), 32'd1);
      step();
    end
    mem_ready_in      = 1'b1;
    mem_read_value_in = 32'h55AA_55AA;
    push(1'b1, 32'h0000_0040, 1'b1, 1'b0, 4'h0, 32'h0, 32'h55AA_55AA);
    step();
    data_read_in      = 1'b0;
    data_address_in   = '0;
    mem_read_value_in = 32'h1111_0000;
    push(1'b0, 32'h0000_0500, 1'b1, 1'b0, 4'h0, 32'h0, 32'h1111_0000);
    step();
    clear_inputs();

    // Fairness with limit 2: D,D,I,D,D,I
    step();
    instr_read_in       = 1'b1;
    instr_address_in    = 32'h0000_0300;
    data_read_in        = 1'b1;
    data_address_in     = 32'h0000_0400;
    data_write_mask_in  = 4'h5;
    data_write_value_in = 32'h0000_0077;
    mem_ready_in        = 1'b1;
    mem_read_value_in   = 32'h600D_0000;
    for (int i = 0; i < 6; i++) begin
      if (i % 3 == 2)
        push(1'b0, 32'h0000_0300, 1'b1, 1'b0, 4'h0, 32'h0, 32'h600D_0000);
      else
        push(1'b1, 32'h0000_0400, 1'b1, 1'b0, 4'h5, 32'h0000_0077, 32'h600D_0000);
      step();
    end
    clear_inputs();

    // Reset in the middle of a stalled data write
    step();
    data_write_in       = 1'b1;
    data_address_in     = 32'h0000_0060;
    data_write_mask_in  = 4'h3;
    data_write_value_in = 32'hA5A5_A5A5;
    mem_ready_in        = 1'b0;
    @(negedge clk);
    chk("busy_mem_write", 32'(mem_write_out), 32'd1);
    chk("busy_mem_addr", mem_address_out, 32'h0000_0060);
    #2;
    reset = 1'b0;
    #1;
    check_quiet("async_reset");
    step();
    clear_inputs();
    reset = 1'b1;
    instr_read_in     = 1'b1;
    instr_address_in  = 32'h0000_0700;
    mem_ready_in      = 1'b1;
    mem_read_value_in = 32'h7000_7000;
    push(1'b0, 32'h0000_0700, 1'b1, 1'b0, 4'h0, 32'h0, 32'h7000_7000);
    step();
    clear_inputs();

    // Idle bus while mem_ready_in toggles
    for (int i = 0; i < 4; i++) begin
      step();
      mem_ready_in      = i[0];
      mem_read_value_in = 32'hFFFF_0000 + 32'(i);
      @(negedge clk);
      check_quiet("idle");
    end

    step();
    step();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
